// File: rtl/aha_sram_arbiter_if.sv
// Requester-side port bundle for the SRAM arbiter. Requesters use the master
// modport; the arbiter uses the slave modport, one instance per port.
interface aha_sram_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic [DATA_WIDTH/8-1:0]   we;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      lock;
  logic                      gnt;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/aha_sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro with
// active-low chip/byte enables and one-cycle read latency. A port can lock the
// SRAM for read-modify-write sequences; read data is tagged back to the issuer.
module aha_sram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  aha_sram_arbiter_if.slave         p0,
  aha_sram_arbiter_if.slave         p1,
  output logic                      sram_cen,
  output logic [DATA_WIDTH/8-1:0]   sram_wen,
  output logic [ADDR_WIDTH-1:0]     sram_a,
  output logic [DATA_WIDTH-1:0]     sram_d,
  input  logic [DATA_WIDTH-1:0]     sram_q
);

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] is_rd;
  logic [1:0] gnt;

  logic       prio_q, prio_d;
  logic       owner_vld_q, owner_vld_d;
  logic       owner_q, owner_d;
  logic [1:0] rd_pend_q, rd_pend_d;

  assign req   = {p1.req, p0.req};
  assign lock  = {p1.lock, p0.lock};
  assign is_rd = {~|p1.we, ~|p0.we};

  // Combinational grant: lock owner first, then single requester, then prio.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (owner_vld_q) begin
      gnt[owner_q] = req[owner_q];
    end else if (req == 2'b11) begin
      gnt[prio_q] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // SRAM pin drive; idle cycles park address/data on port 0 to avoid toggling.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = '1;
    sram_a   = p0.addr;
    sram_d   = p0.wdata;
    if (gnt[0]) begin
      sram_cen = 1'b0;
      sram_wen = ~p0.we;
    end else if (gnt[1]) begin
      sram_cen = 1'b0;
      sram_wen = ~p1.we;
      sram_a   = p1.addr;
      sram_d   = p1.wdata;
    end
  end

  // Next-state: round-robin pointer, lock ownership (set beats clear), read tags.
  always_comb begin
    prio_d      = prio_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
    if (owner_vld_q && !lock[owner_q]) begin
      owner_vld_d = 1'b0;
    end
    if (gnt[0] && lock[0]) begin
      owner_vld_d = 1'b1;
      owner_d     = 1'b0;
    end else if (gnt[1] && lock[1]) begin
      owner_vld_d = 1'b1;
      owner_d     = 1'b1;
    end
    rd_pend_d = gnt & is_rd;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q      <= 1'b0;
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      rd_pend_q   <= 2'b00;
    end else begin
      prio_q      <= prio_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rd_pend_q[0];
  assign p1.rvalid = rd_pend_q[1];
  assign p0.rdata  = sram_q;
  assign p1.rdata  = sram_q;

endmodule

// File: tb/tb_aha_sram_arbiter.sv
// Bench for aha_sram_arbiter: per-cycle vector table with expected grants,
// an SRAM behavioural model, and a read-data scoreboard keyed by due cycle.
module tb_aha_sram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sram_cen;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  aha_sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
  aha_sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

  aha_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0       (p0_if),
    .p1       (p1_if),
    .sram_cen (sram_cen),
    .sram_wen (sram_wen),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q)
  );

  always #5 clk = ~clk;

  // SRAM macro model: one-cycle read latency, active-low byte writes.
  logic [DW-1:0] mem [0:32767];
  initial for (int i = 0; i < 32768; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (&sram_wen) begin
        sram_q <= mem[sram_a];
      end else begin
        for (int b = 0; b < 4; b++)
          if (!sram_wen[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic          rst;
    logic          r0;
    logic [3:0]    we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          l0;
    logic          r1;
    logic [3:0]    we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          l1;
    logic          eg0;
    logic          eg1;
  } vec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          vecs[$];
  sb_t           sbq[2][$];
  logic [DW-1:0] ref_mem [int];
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;

  function automatic void add(logic rst_i,
                              logic r0, logic [3:0] we0, logic [AW-1:0] a0, logic [DW-1:0] d0, logic l0,
                              logic r1, logic [3:0] we1, logic [AW-1:0] a1, logic [DW-1:0] d1, logic l1,
                              logic eg0, logic eg1);
    vec_t v;
    v.rst = rst_i;
    v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
    v.eg0 = eg0; v.eg1 = eg1;
    vecs.push_back(v);
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return '0;
  endfunction

  function automatic void ref_wr(logic [AW-1:0] a, logic [3:0] we, logic [DW-1:0] d);
    logic [DW-1:0] t;
    t = ref_rd(a);
    for (int b = 0; b < 4; b++)
      if (we[b]) t[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a)] = t;
  endfunction

  task automatic step(input vec_t v);
    logic [1:0]    g;
    logic [1:0]    rv;
    logic [DW-1:0] rd [2];
    logic          exp_cen;
    logic [3:0]    exp_wen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    rst = v.rst;
    p0_if.req = v.r0; p0_if.we = v.we0; p0_if.addr = v.a0; p0_if.wdata = v.d0; p0_if.lock = v.l0;
    p1_if.req = v.r1; p1_if.we = v.we1; p1_if.addr = v.a1; p1_if.wdata = v.d1; p1_if.lock = v.l1;
    #1;
    cyc++;
    g  = {p1_if.gnt, p0_if.gnt};
    rv = {p1_if.rvalid, p0_if.rvalid};
    rd[0] = p0_if.rdata;
    rd[1] = p1_if.rdata;
    chk("p0_gnt", 64'(g[0]), 64'(v.eg0));
    chk("p1_gnt", 64'(g[1]), 64'(v.eg1));

    exp_cen = 1'b1; exp_wen = 4'hF; exp_a = v.a0; exp_d = v.d0;
    if (v.eg0) begin
      exp_cen = 1'b0; exp_wen = ~v.we0;
    end else if (v.eg1) begin
      exp_cen = 1'b0; exp_wen = ~v.we1; exp_a = v.a1; exp_d = v.d1;
    end
    chk("sram_pins", 64'({sram_cen, sram_wen, sram_a, sram_d}),
                     64'({exp_cen, exp_wen, exp_a, exp_d}));

    if (v.rst) begin
      sbq[0].delete();
      sbq[1].delete();
    end
    for (int p = 0; p < 2; p++) begin
      if (sbq[p].size() > 0 && sbq[p][0].due == cyc) begin
        chk(p == 0 ? "p0_rvalid_rdata" : "p1_rvalid_rdata",
            64'({rv[p], rd[p]}), 64'({1'b1, sbq[p][0].data}));
        void'(sbq[p].pop_front());
      end else begin
        chk(p == 0 ? "p0_rvalid_idle" : "p1_rvalid_idle", 64'(rv[p]), 64'(0));
      end
    end

    if (g[0]) begin
      if (v.we0 == 4'h0) sbq[0].push_back('{due: cyc + 1, data: ref_rd(v.a0)});
      else               ref_wr(v.a0, v.we0, v.d0);
    end
    if (g[1]) begin
      if (v.we1 == 4'h0) sbq[1].push_back('{due: cyc + 1, data: ref_rd(v.a1)});
      else               ref_wr(v.a1, v.we1, v.d1);
    end
  endtask

  initial begin
    p0_if.req = 0; p0_if.we = 0; p0_if.addr = 0; p0_if.wdata = 0; p0_if.lock = 0;
    p1_if.req = 0; p1_if.we = 0; p1_if.addr = 0; p1_if.wdata = 0; p1_if.lock = 0;

    //  rst r0 we0   a0       d0            l0 r1 we1   a1      d1            l1 eg0 eg1
    // reset held with both requesting, then port 0 wins first
    add(1, 1, 4'h0, 15'h0010, 32'h0,        0, 1, 4'h0, 15'h20, 32'h0,        0, 0, 0);
    add(0, 1, 4'h0, 15'h0010, 32'h0,        0, 1, 4'h0, 15'h20, 32'h0,        0, 1, 0);
    // single-port write / read / byte write / read
    add(0, 1, 4'hF, 15'h1234, 32'hDEADBEEF, 0, 0, 4'h0, 15'h0,  32'h0,        0, 1, 0);
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 0, 4'h0, 15'h0,  32'h0,        0, 1, 0);
    add(0, 1, 4'h2, 15'h1234, 32'h0000AA00, 0, 0, 4'h0, 15'h0,  32'h0,        0, 1, 0);
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 0, 4'h0, 15'h0,  32'h0,        0, 1, 0);
    add(0, 0, 4'h0, 15'h0,    32'h0,        0, 0, 4'h0, 15'h0,  32'h0,        0, 0, 0);
    // port 1 single write
    add(0, 0, 4'h0, 15'h0,    32'h0,        0, 1, 4'hF, 15'h20, 32'h12345678, 0, 0, 1);
    // contention: 8 cycles of both reading, grants alternate from port 0
    for (int i = 0; i < 8; i++)
      add(0, 1, 4'h0, 15'h1234, 32'h0,      0, 1, 4'h0, 15'h20, 32'h0,        0, (i % 2) == 0, (i % 2) == 1);
    // lock: p1 locked read, then owner wins over prio, then idles holding lock
    add(0, 0, 4'h0, 15'h1234, 32'h0,        0, 1, 4'h0, 15'h20, 32'h0,        1, 0, 1);
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 1, 4'h0, 15'h20, 32'h0,        1, 0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 1, 4'h0, 15'h1234, 32'h0,      0, 0, 4'h0, 15'h20, 32'h0,        1, 0, 0);
    // lock dropped: still blocked this cycle, p0 granted the next
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 0, 4'h0, 15'h20, 32'h0,        0, 0, 0);
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 0, 4'h0, 15'h20, 32'h0,        0, 1, 0);
    // idle 10 cycles, then tie goes to port 1 (port 0 was granted last)
    for (int i = 0; i < 10; i++)
      add(0, 0, 4'h0, 15'h0,  32'h0,        0, 0, 4'h0, 15'h0,  32'h0,        0, 0, 0);
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 1, 4'h0, 15'h20, 32'h0,        0, 0, 1);
    // reset mid-read with p0 holding a lock: rvalid dropped, lock released
    add(0, 1, 4'h0, 15'h1234, 32'h0,        1, 0, 4'h0, 15'h20, 32'h0,        0, 1, 0);
    add(1, 0, 4'h0, 15'h1234, 32'h0,        1, 1, 4'h0, 15'h20, 32'h0,        0, 0, 0);
    add(0, 0, 4'h0, 15'h1234, 32'h0,        1, 1, 4'h0, 15'h20, 32'h0,        0, 0, 1);
    // reset returns prio to 0
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 0, 4'h0, 15'h20, 32'h0,        0, 1, 0);
    add(1, 0, 4'h0, 15'h1234, 32'h0,        0, 0, 4'h0, 15'h20, 32'h0,        0, 0, 0);
    add(0, 1, 4'h0, 15'h1234, 32'h0,        0, 1, 4'h0, 15'h20, 32'h0,        0, 1, 0);
    add(0, 0, 4'h0, 15'h0,    32'h0,        0, 0, 4'h0, 15'h0,  32'h0,        0, 0, 0);

    foreach (vecs[i]) step(vecs[i]);

    // hand-written: byte-write result read back explicitly through port 1
    tests++;
    if (ref_rd(15'h1234) !== 32'hDEADAAEF) begin
      fails++;
      $display("FAIL ref_byte_merge: got %h expected %h", ref_rd(15'h1234), 32'hDEADAAEF);
    end
    step('{rst: 0, r0: 0, we0: 4'h0, a0: 15'h0, d0: 32'h0, l0: 0,
           r1: 1, we1: 4'h0, a1: 15'h1234, d1: 32'h0, l1: 0, eg0: 0, eg1: 1});
    step('{rst: 0, r0: 0, we0: 4'h0, a0: 15'h0, d0: 32'h0, l0: 0,
           r1: 0, we1: 4'h0, a1: 15'h0, d1: 32'h0, l1: 0, eg0: 0, eg1: 0});
    chk("sram_mem_1234", 64'(mem[15'h1234]), 64'(32'hDEADAAEF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
